// File: rtl/victim_cache_ctrl_pkg.sv
// Shared types for the LC-3b victim cache: victim tag/index types, controller
// state encodings and the address-to-tag helper.
package victim_cache_ctrl_pkg;

    typedef logic [10:0] lc3b_c_vic_tag;
    typedef logic [2:0]  lc3b_c_vic_index;
    typedef logic [1:0]  vc_state_t;

    localparam vc_state_t S_IDLE  = 2'd0;
    localparam vc_state_t S_HIT   = 2'd1;
    localparam vc_state_t S_WB    = 2'd2;
    localparam vc_state_t S_FETCH = 2'd3;

    function automatic lc3b_c_vic_tag addr_tag(input logic [15:0] addr);
        return addr[15:5];
    endfunction

endpackage

// File: rtl/victim_tag_cam.sv
// Tag/valid/dirty store for the victim slots with a fully parallel tag match
// and a random-access read port for the controller's replacement decisions.
module victim_tag_cam
    import victim_cache_ctrl_pkg::*;
#(
    parameter int entries = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  lc3b_c_vic_tag   lookup_tag,
    input  logic            write_en,
    input  lc3b_c_vic_index write_index,
    input  logic            write_valid,
    input  logic            write_dirty,
    input  lc3b_c_vic_tag   write_tag,
    input  lc3b_c_vic_index read_index,
    output logic            hit,
    output lc3b_c_vic_index hit_index,
    output lc3b_c_vic_index first_invalid,
    output logic            any_invalid,
    output logic            read_valid,
    output logic            read_dirty,
    output lc3b_c_vic_tag   read_tag
);

    lc3b_c_vic_tag       tags [entries];
    logic [entries-1:0]  valid;
    logic [entries-1:0]  dirty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (write_en) begin
            valid[write_index] <= write_valid;
            dirty[write_index] <= write_dirty;
        end
    end

    // Tags carry no meaning while their valid bit is clear, so they are not reset.
    always_ff @(posedge clk) begin
        if (write_en)
            tags[write_index] <= write_tag;
    end

    always_comb begin
        hit           = 1'b0;
        hit_index     = '0;
        first_invalid = '0;
        any_invalid   = 1'b0;
        for (int i = entries - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == lookup_tag) begin
                hit       = 1'b1;
                hit_index = lc3b_c_vic_index'(i);
            end
            if (!valid[i]) begin
                any_invalid   = 1'b1;
                first_invalid = lc3b_c_vic_index'(i);
            end
        end
    end

    assign read_valid = valid[read_index];
    assign read_dirty = dirty[read_index];
    assign read_tag   = tags[read_index];

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller between an L1 and physical memory.
// Define VC_STATS_EN to add saturating hit_count/miss_count outputs.
module victim_cache_ctrl
    import victim_cache_ctrl_pkg::*;
#(
    parameter int width   = 256,
    parameter int entries = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l1_req,
    input  logic [15:0]      l1_addr,
    output logic             l1_resp,
    output logic [width-1:0] l1_rdata,
    input  logic             ev_valid,
    input  logic [15:0]      ev_addr,
    input  logic             ev_dirty,
    input  logic [width-1:0] ev_data,
    output logic             va_load,
    output logic [2:0]       va_index,
    output logic [width-1:0] va_in,
    input  logic [width-1:0] va_out,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    output logic [width-1:0] pmem_wdata,
    input  logic [width-1:0] pmem_rdata,
    input  logic             pmem_resp
`ifdef VC_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);

    vc_state_t       state;
    lc3b_c_vic_index slot_q;
    lc3b_c_vic_index pointer;
    logic            repl_was_valid;

    logic            hit, any_invalid, read_valid, read_dirty;
    lc3b_c_vic_index hit_index, first_invalid, repl_index, read_index;
    lc3b_c_vic_tag   read_tag;
    logic            cam_write_en, cam_write_valid, cam_write_dirty;
    lc3b_c_vic_tag   cam_write_tag;

    assign repl_index = any_invalid ? first_invalid : pointer;
    assign read_index = (state == S_IDLE) ? repl_index : slot_q;

    victim_tag_cam #(.entries(entries)) u_cam (
        .clk           (clk),
        .reset         (reset),
        .lookup_tag    (addr_tag(l1_addr)),
        .write_en      (cam_write_en),
        .write_index   (slot_q),
        .write_valid   (cam_write_valid),
        .write_dirty   (cam_write_dirty),
        .write_tag     (cam_write_tag),
        .read_index    (read_index),
        .hit           (hit),
        .hit_index     (hit_index),
        .first_invalid (first_invalid),
        .any_invalid   (any_invalid),
        .read_valid    (read_valid),
        .read_dirty    (read_dirty),
        .read_tag      (read_tag)
    );

    // Write-back only happens when an eviction is about to displace a dirty victim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            slot_q         <= '0;
            pointer        <= '0;
            repl_was_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (l1_req) begin
                        if (hit) begin
                            state  <= S_HIT;
                            slot_q <= hit_index;
                        end else begin
                            slot_q         <= repl_index;
                            repl_was_valid <= read_valid;
                            state <= (ev_valid && read_valid && read_dirty) ? S_WB : S_FETCH;
                        end
                    end
                end
                S_HIT:  state <= S_IDLE;
                S_WB:   if (pmem_resp) state <= S_FETCH;
                S_FETCH: begin
                    if (pmem_resp) begin
                        state <= S_IDLE;
                        if (ev_valid && repl_was_valid)
                            pointer <= pointer + 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        l1_resp         = 1'b0;
        l1_rdata        = '0;
        va_load         = 1'b0;
        va_index        = slot_q;
        va_in           = '0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = '0;
        pmem_wdata      = '0;
        cam_write_en    = 1'b0;
        cam_write_valid = 1'b0;
        cam_write_dirty = 1'b0;
        cam_write_tag   = addr_tag(ev_addr);
        case (state)
            S_IDLE: va_index = repl_index;
            S_HIT: begin
                l1_resp         = 1'b1;
                l1_rdata        = va_out;
                cam_write_en    = 1'b1;
                cam_write_valid = ev_valid;
                cam_write_dirty = ev_valid && ev_dirty;
                va_load         = ev_valid;
                if (ev_valid)
                    va_in = ev_data;
            end
            S_WB: begin
                pmem_write   = 1'b1;
                pmem_wdata   = va_out;
                pmem_address = {read_tag, 5'b0};
            end
            S_FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {addr_tag(l1_addr), 5'b0};
                if (pmem_resp) begin
                    l1_resp  = 1'b1;
                    l1_rdata = pmem_rdata;
                    if (ev_valid) begin
                        va_load         = 1'b1;
                        va_in           = ev_data;
                        cam_write_en    = 1'b1;
                        cam_write_valid = 1'b1;
                        cam_write_dirty = ev_dirty;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef VC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == S_IDLE && l1_req && hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (((state == S_IDLE && l1_req && !hit && !(ev_valid && read_valid && read_dirty)) ||
                 (state == S_WB && pmem_resp)) && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed self-checking bench for victim_cache_ctrl with a behavioural
// victim data array and a hand-driven memory response.
module tb_victim_cache_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         l1_req = 1'b0;
    logic [15:0]  l1_addr = '0;
    logic         l1_resp;
    logic [255:0] l1_rdata;
    logic         ev_valid = 1'b0;
    logic [15:0]  ev_addr = '0;
    logic         ev_dirty = 1'b0;
    logic [255:0] ev_data = '0;
    logic         va_load;
    logic [2:0]   va_index;
    logic [255:0] va_in;
    logic [255:0] va_out;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    logic [255:0] va_mem [8];
    int checks = 0;
    int errors = 0;

    victim_cache_ctrl #(.width(256), .entries(8)) dut (
        .clk(clk), .reset(reset),
        .l1_req(l1_req), .l1_addr(l1_addr), .l1_resp(l1_resp), .l1_rdata(l1_rdata),
        .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_dirty(ev_dirty), .ev_data(ev_data),
        .va_load(va_load), .va_index(va_index), .va_in(va_in), .va_out(va_out),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) va_mem[i] = '0;
    always @(posedge clk) if (va_load) va_mem[va_index] <= va_in;
    assign va_out = va_mem[va_index];

    function automatic logic [255:0] pat(input int n);
        return {8{32'hA5000000 + 32'(n)}};
    endfunction

    task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_miss(input logic [15:0] l1a, input logic ev, input logic [15:0] eva,
                           input logic evd, input logic [255:0] evdat, input logic [255:0] fdat,
                           input logic exp_wb, input logic [15:0] wb_a, input logic [255:0] wb_dat,
                           input logic [2:0] exp_slot);
        l1_req = 1'b1; l1_addr = l1a; ev_valid = ev; ev_addr = eva; ev_dirty = evd; ev_data = evdat;
        #1;
        if (ev) check_output("idle_va_index", va_index, exp_slot);
        @(posedge clk); #1;
        if (exp_wb) begin
            check_output("wb_pmem_write", pmem_write, 1'b1);
            check_output("wb_pmem_read", pmem_read, 1'b0);
            check_output("wb_address", pmem_address, wb_a);
            check_output("wb_wdata", pmem_wdata, wb_dat);
            check_output("wb_va_index", va_index, exp_slot);
            pmem_resp = 1'b1;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            #1;
        end
        check_output("fetch_pmem_read", pmem_read, 1'b1);
        check_output("fetch_pmem_write", pmem_write, 1'b0);
        check_output("fetch_address", pmem_address, {l1a[15:5], 5'b0});
        check_output("fetch_l1_resp_early", l1_resp, 1'b0);
        pmem_rdata = fdat; pmem_resp = 1'b1;
        #1;
        check_output("fetch_l1_resp", l1_resp, 1'b1);
        check_output("fetch_l1_rdata", l1_rdata, fdat);
        check_output("fetch_va_load", va_load, ev);
        if (ev) begin
            check_output("fetch_va_index", va_index, exp_slot);
            check_output("fetch_va_in", va_in, evdat);
        end
        @(posedge clk); #1;
        pmem_resp = 1'b0; l1_req = 1'b0; ev_valid = 1'b0;
        #1;
        check_output("post_miss_l1_resp", l1_resp, 1'b0);
    endtask

    task automatic do_hit(input logic [15:0] l1a, input logic ev, input logic [15:0] eva,
                          input logic evd, input logic [255:0] evdat, input logic [255:0] exp_data,
                          input logic [2:0] exp_slot);
        l1_req = 1'b1; l1_addr = l1a; ev_valid = ev; ev_addr = eva; ev_dirty = evd; ev_data = evdat;
        #1;
        check_output("hit_idle_l1_resp", l1_resp, 1'b0);
        @(posedge clk); #1;
        check_output("hit_l1_resp", l1_resp, 1'b1);
        check_output("hit_l1_rdata", l1_rdata, exp_data);
        check_output("hit_va_index", va_index, exp_slot);
        check_output("hit_va_load", va_load, ev);
        check_output("hit_pmem_read", pmem_read, 1'b0);
        if (ev) check_output("hit_va_in", va_in, evdat);
        @(posedge clk); #1;
        l1_req = 1'b0; ev_valid = 1'b0;
        #1;
        check_output("post_hit_l1_resp", l1_resp, 1'b0);
    endtask

    task automatic applyStimulus_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    initial begin
        applyStimulus_reset();
        check_output("reset_l1_resp", l1_resp, 1'b0);
        check_output("reset_pmem_read", pmem_read, 1'b0);
        check_output("reset_pmem_write", pmem_write, 1'b0);
        check_output("reset_va_load", va_load, 1'b0);
        check_output("reset_va_index", va_index, 3'd0);
        check_output("reset_l1_rdata", l1_rdata, '0);

        // Plain miss with nothing to evict, then insert, hit and re-miss.
        do_miss(16'h1000, 1'b0, 16'h0, 1'b0, '0, pat(200), 1'b0, 16'h0, '0, 3'd0);
        do_miss(16'h2000, 1'b1, 16'h1000, 1'b0, pat(1), pat(201), 1'b0, 16'h0, '0, 3'd0);
        do_hit(16'h1000, 1'b0, 16'h0, 1'b0, '0, pat(1), 3'd0);
        do_miss(16'h1000, 1'b0, 16'h0, 1'b0, '0, pat(202), 1'b0, 16'h0, '0, 3'd0);

        // Hit with eviction swaps the slot contents in place.
        do_miss(16'h4000, 1'b1, 16'h3000, 1'b0, pat(3), pat(203), 1'b0, 16'h0, '0, 3'd0);
        do_hit(16'h3000, 1'b1, 16'h5000, 1'b1, pat(4), pat(3), 3'd0);
        do_hit(16'h5000, 1'b0, 16'h0, 1'b0, '0, pat(4), 3'd0);

        // Fill all eight slots dirty, then force round-robin write-backs.
        applyStimulus_reset();
        for (int i = 0; i < 8; i++)
            do_miss(16'hA000 + 16'(i * 32), 1'b1, 16'h1000 + 16'(i * 32), 1'b1, pat(i),
                    pat(100 + i), 1'b0, 16'h0, '0, 3'(i));
        do_miss(16'hB000, 1'b1, 16'h2000, 1'b1, pat(8), pat(108), 1'b1, 16'h1000, pat(0), 3'd0);
        do_miss(16'hB020, 1'b1, 16'h2020, 1'b1, pat(9), pat(109), 1'b1, 16'h1020, pat(1), 3'd1);
        do_hit(16'h2000, 1'b0, 16'h0, 1'b0, '0, pat(8), 3'd0);
        do_miss(16'hB040, 1'b1, 16'h2040, 1'b0, pat(10), pat(110), 1'b0, 16'h0, '0, 3'd0);

        // Reset while a write-back is outstanding.
        l1_req = 1'b1; l1_addr = 16'hB060; ev_valid = 1'b1; ev_addr = 16'h2060; ev_dirty = 1'b1;
        ev_data = pat(11);
        #1;
        check_output("wb2_idle_va_index", va_index, 3'd2);
        @(posedge clk); #1;
        check_output("wb2_pmem_write", pmem_write, 1'b1);
        check_output("wb2_address", pmem_address, 16'h1040);
        check_output("wb2_wdata", pmem_wdata, pat(2));
        reset = 1'b1;
        #1;
        check_output("rst_wb_pmem_write", pmem_write, 1'b0);
        check_output("rst_wb_l1_resp", l1_resp, 1'b0);
        check_output("rst_wb_va_index", va_index, 3'd0);
        l1_req = 1'b0; ev_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        do_miss(16'h1060, 1'b0, 16'h0, 1'b0, '0, pat(300), 1'b0, 16'h0, '0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
